// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Purpose  : IF/ID pipeline register for the 16-bit, 4-bit-opcode processor.
//            Accepts fetched instructions and their PCs over a valid/ready
//            handshake. Each instruction is presented as four 4-bit fields
//            for the ID stage. A two-entry buffer (main output entry plus one
//            skid entry) absorbs hazard stalls without losing a fetched
//            instruction. A branch flush squashes everything in flight.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            if_instr, if_pc       - fetched instruction word and its PC
//            if_valid / if_ready   - fetch-side handshake (if_ready = !skid)
//            id_stall              - hazard unit holds the ID stage
//            flush                 - squash buffered and incoming entries
//            id_opcode..id_three   - instr[15:12], [11:8], [7:4], [3:0]
//            id_pc, id_valid       - PC and valid of the output entry
//            stall_cnt, flush_cnt  - saturating event counters
// Options  : IFID_PERF_EN - when defined, adds stall_cnt/flush_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_reg #(
    parameter int          PC_W      = 16,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [15:0]     if_instr,
    input  logic [PC_W-1:0] if_pc,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic            id_stall,
    input  logic            flush,
    output logic [3:0]      id_opcode,
    output logic [3:0]      id_one,
    output logic [3:0]      id_two,
    output logic [3:0]      id_three,
    output logic [PC_W-1:0] id_pc,
`ifdef IFID_PERF_EN
    output logic [15:0]     stall_cnt,
    output logic [15:0]     flush_cnt,
`endif
    output logic            id_valid
);

    logic [15:0]     r_main_instr;
    logic [PC_W-1:0] r_main_pc;
    logic            r_main_valid;
    logic [15:0]     r_skid_instr;
    logic [PC_W-1:0] r_skid_pc;
    logic            r_skid_valid;

    logic            w_acc;
    logic            w_adv;

    // if_ready comes straight from the skid valid flop, so the fetch side
    // never sees a combinational path from id_stall or flush.
    assign if_ready = ~r_skid_valid;
    assign w_acc    = if_valid & ~r_skid_valid;
    // A bubble in main can always be overwritten, even while stalled.
    assign w_adv    = ~id_stall | ~r_main_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_instr <= NOP_INSTR;
            r_main_pc    <= '0;
            r_main_valid <= 1'b0;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc    <= '0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            // Anything accepted this cycle is dropped along with the buffer.
            r_main_instr <= NOP_INSTR;
            r_main_pc    <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_adv) begin
            if (r_skid_valid) begin
                // if_ready is low here, so no new input competes with skid.
                r_main_instr <= r_skid_instr;
                r_main_pc    <= r_skid_pc;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_acc) begin
                r_main_instr <= if_instr;
                r_main_pc    <= if_pc;
                r_main_valid <= 1'b1;
            end else begin
                r_main_instr <= NOP_INSTR;
                r_main_pc    <= '0;
                r_main_valid <= 1'b0;
            end
        end else if (w_acc) begin
            // Main is stalled with a real instruction: park input in skid.
            r_skid_instr <= if_instr;
            r_skid_pc    <= if_pc;
            r_skid_valid <= 1'b1;
        end
    end

    // Invalid main always holds NOP_INSTR, so the fields are a plain slice.
    assign id_opcode = r_main_instr[15:12];
    assign id_one    = r_main_instr[11:8];
    assign id_two    = r_main_instr[7:4];
    assign id_three  = r_main_instr[3:0];
    assign id_pc     = r_main_pc;
    assign id_valid  = r_main_valid;

`ifdef IFID_PERF_EN
    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (id_stall && r_main_valid && (r_stall_cnt != C_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            // Only flushes that actually squash something are counted.
            if (flush && (r_main_valid || r_skid_valid) && (r_flush_cnt != C_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_reg
// Purpose  : Self-checking bench for if_id_reg. The reference model treats the
//            block as an in-order queue of at most two in-flight instructions:
//            the head is what the ID stage sees, the ID stage consumes the
//            head whenever it is not stalled, a new word is accepted while
//            fewer than two are held, and a flush empties the queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_reg;

    localparam int          PC_W      = 16;
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef struct packed {
        logic [15:0]     instr;
        logic [PC_W-1:0] pc;
    } ent_t;

    logic            clk;
    logic            rst_n;
    logic [15:0]     if_instr;
    logic [PC_W-1:0] if_pc;
    logic            if_valid;
    logic            if_ready;
    logic            id_stall;
    logic            flush;
    logic [3:0]      id_opcode;
    logic [3:0]      id_one;
    logic [3:0]      id_two;
    logic [3:0]      id_three;
    logic [PC_W-1:0] id_pc;
    logic            id_valid;
`ifdef IFID_PERF_EN
    logic [15:0]     stall_cnt;
    logic [15:0]     flush_cnt;
`endif

    ent_t            exp_q[$];
    int              n_vec;
    int              n_err;
    logic            mon_en;
    int              m_stall;
    int              m_flush;

    if_id_reg #(
        .PC_W      (PC_W),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_instr  (if_instr),
        .if_pc     (if_pc),
        .if_valid  (if_valid),
        .if_ready  (if_ready),
        .id_stall  (id_stall),
        .flush     (flush),
        .id_opcode (id_opcode),
        .id_one    (id_one),
        .id_two    (id_two),
        .id_three  (id_three),
        .id_pc     (id_pc),
`ifdef IFID_PERF_EN
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
`endif
        .id_valid  (id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the presented output entry against the queue head
    // each cycle and retires the head when the ID stage takes it.
    always begin
        @(negedge clk);
        #1;
        if (mon_en) begin
            chk("if_ready", {31'd0, if_ready}, {31'd0, (exp_q.size() < 2)});
            chk("id_valid", {31'd0, id_valid}, {31'd0, (exp_q.size() > 0)});
            if (exp_q.size() > 0) begin
                chk("fields", {16'd0, id_opcode, id_one, id_two, id_three}, {16'd0, exp_q[0].instr});
                chk("id_pc", {16'd0, id_pc}, {16'd0, exp_q[0].pc});
                if (!id_stall && !flush) begin
                    void'(exp_q.pop_front());
                end
            end else begin
                chk("nop_fields", {16'd0, id_opcode, id_one, id_two, id_three}, {16'd0, NOP_INSTR});
                chk("nop_pc", {16'd0, id_pc}, 32'd0);
            end
`ifdef IFID_PERF_EN
            chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
            chk("flush_cnt", {16'd0, flush_cnt}, m_flush);
`endif
        end
    end

    // One clock cycle of stimulus; the model is advanced after the monitor
    // has retired this cycle's consumed head.
    task automatic cycle(input logic v, input logic [15:0] ins, input logic [PC_W-1:0] pc,
                         input logic st, input logic fl);
        logic rdy;
        int   occ;
        @(negedge clk);
        if_valid = v;
        if_instr = ins;
        if_pc    = pc;
        id_stall = st;
        flush    = fl;
        occ      = exp_q.size();
        rdy      = (occ < 2);
        #2;
        if (st && occ > 0 && m_stall < 65535) m_stall++;
        if (fl && occ > 0 && m_flush < 65535) m_flush++;
        if (fl) begin
            exp_q.delete();
        end else if (v && rdy) begin
            exp_q.push_back('{instr: ins, pc: pc});
        end
    endtask

    task automatic fill_both();
        cycle(1'b1, 16'h8001, 16'h0100, 1'b0, 1'b0);
        cycle(1'b1, 16'hB002, 16'h0101, 1'b1, 1'b0);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        m_stall  = 0;
        m_flush  = 0;
        mon_en   = 1'b0;
        rst_n    = 1'b0;
        if_valid = 1'b0;
        if_instr = 16'h0;
        if_pc    = '0;
        id_stall = 1'b0;
        flush    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_if_ready", {31'd0, if_ready}, 32'd1);
        chk("rst_fields", {16'd0, id_opcode, id_one, id_two, id_three}, {16'd0, NOP_INSTR});
        chk("rst_pc", {16'd0, id_pc}, 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Back-to-back stream
        cycle(1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0);
        cycle(1'b1, 16'h4A5F, 16'h0001, 1'b0, 1'b0);
        cycle(1'b1, 16'hC789, 16'h0002, 1'b0, 1'b0);
        chk("stream_op",    {28'd0, id_opcode}, 32'h4);
        chk("stream_one",   {28'd0, id_one},    32'hA);
        chk("stream_two",   {28'd0, id_two},    32'h5);
        chk("stream_three", {28'd0, id_three},  32'hF);
        chk("stream_valid", {31'd0, id_valid},  32'd1);
        chk("stream_ready", {31'd0, if_ready},  32'd1);
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

        // Stall into skid, then release
        fill_both();
        cycle(1'b1, 16'hEEEE, 16'h0102, 1'b1, 1'b0);
        chk("skid_ready_low", {31'd0, if_ready}, 32'd0);
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("release_instr", {16'd0, id_opcode, id_one, id_two, id_three}, 32'hB002);
        chk("release_ready", {31'd0, if_ready}, 32'd1);
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

        // Flush with both entries full, stall and incoming valid
        fill_both();
        cycle(1'b1, 16'hDEAD, 16'h0200, 1'b1, 1'b1);
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("flush_valid", {31'd0, id_valid}, 32'd0);
        chk("flush_fields", {16'd0, id_opcode, id_one, id_two, id_three}, 32'h0);
        chk("flush_ready", {31'd0, if_ready}, 32'd1);

        // Stall while main is a bubble: loads directly into main
        cycle(1'b1, 16'h5123, 16'h0300, 1'b1, 1'b0);
        cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("bubble_load", {16'd0, id_opcode, id_one, id_two, id_three}, 32'h5123);
        chk("bubble_ready", {31'd0, if_ready}, 32'd1);
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

`ifdef IFID_PERF_EN
        // Three stalled valid cycles, one effective flush, one empty flush
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        m_stall = 0;
        m_flush = 0;
        @(negedge clk);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        rst_n  = 1'b1;
        exp_q.delete();
        mon_en = 1'b1;
        cycle(1'b1, 16'h7777, 16'h0400, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("perf_stall3", {16'd0, stall_cnt}, 32'd3);
        chk("perf_flush1", {16'd0, flush_cnt}, 32'd1);
        // Saturation
        cycle(1'b1, 16'h9999, 16'h0500, 1'b0, 1'b0);
        repeat (65540) cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("perf_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
`endif

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom % 4) != 0, 16'($urandom), PC_W'($urandom),
                  ($urandom % 3) == 0, ($urandom % 16) == 0);
        end

        // Asynchronous reset with both entries full
        fill_both();
        @(negedge clk);
        mon_en   = 1'b0;
        if_valid = 1'b0;
        id_stall = 1'b0;
        flush    = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, id_valid}, 32'd0);
        chk("arst_ready", {31'd0, if_ready}, 32'd1);
        chk("arst_fields", {16'd0, id_opcode, id_one, id_two, id_three}, {16'd0, NOP_INSTR});
        exp_q.delete();
        m_stall = 0;
        m_flush = 0;
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        cycle(1'b1, 16'h2468, 16'h0600, 1'b0, 1'b0);
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("post_rst_accept", {16'd0, id_opcode, id_one, id_two, id_three}, 32'h2468);
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
